tag_store: RTL and testbench
============================

# tag_store

Fully associative tag directory for the victim cache: holds one tag plus valid and dirty bits per way. It supports per-way write, read, invalidate and dirty-bit update, plus an associative lookup returning hit and matching way. It sits beside the victim data array and is driven by the victim cache controller.

## Interface
- `TAG_WIDTH`, default 4: tag width in bits.
- `NUM_WAYS`, default 4: number of entries (ways). Must be a power of two, ≥2.
- Index width `IW` = $clog2(NUM_WAYS).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous reset, active-high (asserted when 1). The historical `_n` suffix does not indicate polarity.
- `write_en` in 1: write `tag_in` into way `way_index_in`.
- `read_en` in 1: read entry `way_index_in` into the read registers.
- `lookup_en` in 1: associative compare of `tag_in` against all ways.
- `tag_in` in TAG_WIDTH: tag for write/lookup.
- `way_index_in` in IW: target way for write/read/valid_clear/dirty_set/dirty_clear.
- `valid_clear` in 1: invalidate way `way_index_in`.
- `dirty_set` in 1: set dirty bit of way `way_index_in`.
- `dirty_clear` in 1: clear dirty bit of way `way_index_in`.
- `hit` out 1: registered lookup result.
- `hit_way_index` out IW: registered matching way.
- `valid_read` out 1: registered valid bit of the read entry.
- `dirty_read` out 1: registered dirty bit of the read entry.
- `tag_read` out TAG_WIDTH: registered tag of the read entry.

## Operation
- Storage per way: `valid`, `dirty`, `tag[TAG_WIDTH-1:0]`.
- Reset (`rst_n`=1, asynchronous): all valid=0, dirty=0, tag=0; all outputs 0.
- Entry update per edge, applied only to way `way_index_in`, priority highest first:
  - `write_en`: tag←`tag_in`, valid←1, dirty←0.
  - `valid_clear`: valid←0, dirty←0; tag retained.
  - `dirty_set`: dirty←1, only if the entry is valid; ignored otherwise.
  - `dirty_clear`: dirty←0.
- Read: when `read_en`=1, `{tag_read, valid_read, dirty_read}` ← stored entry at `way_index_in`. Outputs hold when `read_en`=0. Reading an invalid entry returns its stored tag with valid_read=0.
- Lookup: when `lookup_en`=1, for each way compute match = valid & (tag == `tag_in`).
  - `hit` ← OR of matches.
  - `hit_way_index` ← lowest-index matching way, or 0 on miss.
  - Both outputs hold when `lookup_en`=0.
- Read, lookup and one entry update may occur in the same cycle. Read and lookup always observe pre-edge contents, with no write-through bypass.
- All inputs are single-cycle strobes. There is no handshake or busy state; every request is accepted each cycle.

## Timing
- Entry updates take effect at the rising edge that samples the enable. They are visible to read/lookup issued in the following cycle or later.
- Read latency 1: outputs are valid just after the edge that samples `read_en`=1.
- Lookup latency 1: `hit`/`hit_way_index` are valid just after the edge that samples `lookup_en`=1.
- Asserting reset mid-operation immediately clears all entries and outputs. Strobes present during reset are ignored. Operation resumes at the first edge after deassertion.

## Test plan
- Reset, then write way0=A, way1=B, way2=C; read ways 0,1,2 -> tag_read A/B/C, valid_read=1, dirty_read=0 each; read way3 -> valid_read=0, tag_read=0.
- Lookup B -> hit=1, hit_way_index=1. Lookup C -> hit=1, hit_way_index=2. Lookup F -> hit=0, hit_way_index=0.
- dirty_set way1, read way1 -> dirty_read=1. dirty_clear way1, read way1 -> dirty_read=0. dirty_set on invalid way3, read way3 -> dirty_read=0.
- valid_clear way1, read way1 -> valid_read=0, tag_read=B. Lookup B -> hit=0.
- Duplicate tag: write way3=A, lookup A -> hit_way_index=0. Same-cycle write way2=5 with lookup 5 -> hit=0; next-cycle lookup 5 -> hit=1, way 2.
- Priority: write_en+valid_clear same cycle on way1 -> valid=1. Assert reset asynchronously mid-cycle -> all outputs 0 immediately, and all lookups miss afterwards.

Source files
------------

// File: rtl/tag_store.sv
// Fully associative tag directory for the victim cache: per-way tag, valid and dirty
// state with indexed write/read/maintenance and a registered associative lookup.
module tag_store #(
    parameter int TAG_WIDTH = 4,
    parameter int NUM_WAYS  = 4,
    localparam int IW       = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,          // active-high despite the suffix
    input  logic                 write_en,
    input  logic                 read_en,
    input  logic                 lookup_en,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic [IW-1:0]        way_index_in,
    input  logic                 valid_clear,
    input  logic                 dirty_set,
    input  logic                 dirty_clear,
    output logic                 hit,
    output logic [IW-1:0]        hit_way_index,
    output logic                 valid_read,
    output logic                 dirty_read,
    output logic [TAG_WIDTH-1:0] tag_read
);

    logic [NUM_WAYS-1:0]  valid_q;
    logic [NUM_WAYS-1:0]  dirty_q;
    logic [TAG_WIDTH-1:0] tag_q [NUM_WAYS];

    logic                 match_any;
    logic [IW-1:0]        match_idx;

    // Scanning from the top down lets the lowest matching way win on duplicate tags.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == tag_in)) begin
                match_any = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    // NOTE: the directory is small flop storage, not a RAM macro, so it is cleared
    // by reset; a hit on stale power-up tags would corrupt the victim cache.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM_WAYS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (way_index_in == IW'(i)) begin
                    // NOTE: sequential state uses non-blocking assignment so every
                    // reader in this edge sees pre-edge contents.
                    if (write_en) begin
                        tag_q[i]   <= tag_in;
                        valid_q[i] <= 1'b1;
                        dirty_q[i] <= 1'b0;
                    end else if (valid_clear) begin
                        valid_q[i] <= 1'b0;
                        dirty_q[i] <= 1'b0;
                    end else if (dirty_set) begin
                        if (valid_q[i]) begin
                            dirty_q[i] <= 1'b1;
                        end
                    end else if (dirty_clear) begin
                        dirty_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Read port: samples the pre-edge entry and holds while idle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            valid_read <= 1'b0;
            dirty_read <= 1'b0;
            tag_read   <= '0;
        end else if (read_en) begin
            valid_read <= valid_q[way_index_in];
            dirty_read <= dirty_q[way_index_in];
            tag_read   <= tag_q[way_index_in];
        end
    end

    // Lookup result register: holds while idle, no bypass of same-edge updates.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            hit           <= 1'b0;
            hit_way_index <= '0;
        end else if (lookup_en) begin
            hit           <= match_any;
            hit_way_index <= match_idx;
        end
    end

endmodule

// File: tb/tb_tag_store.sv
// Directed self-checking bench for tag_store using the default 4-bit tag, 4-way build.
module tb_tag_store;

    localparam int TW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          write_en, read_en, lookup_en;
    logic [TW-1:0] tag_in;
    logic [IW-1:0] way_index_in;
    logic          valid_clear, dirty_set, dirty_clear;
    logic          hit;
    logic [IW-1:0] hit_way_index;
    logic          valid_read, dirty_read;
    logic [TW-1:0] tag_read;

    int compared   = 0;
    int mismatched = 0;

    tag_store dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_en     (write_en),
        .read_en      (read_en),
        .lookup_en    (lookup_en),
        .tag_in       (tag_in),
        .way_index_in (way_index_in),
        .valid_clear  (valid_clear),
        .dirty_set    (dirty_set),
        .dirty_clear  (dirty_clear),
        .hit          (hit),
        .hit_way_index(hit_way_index),
        .valid_read   (valid_read),
        .dirty_read   (dirty_read),
        .tag_read     (tag_read)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    task automatic idle();
        write_en = 0; read_en = 0; lookup_en = 0;
        valid_clear = 0; dirty_set = 0; dirty_clear = 0;
        tag_in = '0; way_index_in = '0;
    endtask

    // Apply the strobes already set up, let one edge sample them, then clear them.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_write(input logic [IW-1:0] way, input logic [TW-1:0] tag);
        write_en = 1; way_index_in = way; tag_in = tag;
        tick();
    endtask

    task automatic do_read(input logic [IW-1:0] way);
        read_en = 1; way_index_in = way;
        tick();
    endtask

    task automatic do_lookup(input logic [TW-1:0] tag);
        lookup_en = 1; tag_in = tag;
        tick();
    endtask

    task automatic check_read(input string name, input logic [TW-1:0] t, input logic v, input logic d);
        check({name, ".tag"},   32'(tag_read),   32'(t));
        check({name, ".valid"}, 32'(valid_read), 32'(v));
        check({name, ".dirty"}, 32'(dirty_read), 32'(d));
    endtask

    task automatic check_lookup(input string name, input logic h, input logic [IW-1:0] w);
        check({name, ".hit"}, 32'(hit),           32'(h));
        check({name, ".way"}, 32'(hit_way_index), 32'(w));
    endtask

    initial begin
        idle();
        rst_n = 1;
        #12;
        check_read("reset_rd", 4'h0, 0, 0);
        check_lookup("reset_lk", 0, 0);
        @(posedge clk); #1;
        rst_n = 0;

        do_write(0, 4'hA);
        do_write(1, 4'hB);
        do_write(2, 4'hC);
        do_read(0); check_read("rd_w0", 4'hA, 1, 0);
        do_read(1); check_read("rd_w1", 4'hB, 1, 0);
        do_read(2); check_read("rd_w2", 4'hC, 1, 0);
        do_read(3); check_read("rd_w3_invalid", 4'h0, 0, 0);

        // Outputs hold while read_en is low.
        do_read(0);
        way_index_in = 2; tick();
        check_read("rd_hold", 4'hA, 1, 0);

        do_lookup(4'hB); check_lookup("lk_B", 1, 1);
        do_lookup(4'hC); check_lookup("lk_C", 1, 2);
        tag_in = 4'hB; tick();
        check_lookup("lk_hold", 1, 2);
        do_lookup(4'hF); check_lookup("lk_F_miss", 0, 0);

        dirty_set = 1; way_index_in = 1; tick();
        do_read(1); check_read("dset_w1", 4'hB, 1, 1);
        dirty_clear = 1; way_index_in = 1; tick();
        do_read(1); check_read("dclr_w1", 4'hB, 1, 0);
        dirty_set = 1; way_index_in = 3; tick();
        do_read(3); check_read("dset_invalid_w3", 4'h0, 0, 0);

        valid_clear = 1; way_index_in = 1; tick();
        do_read(1); check_read("vclr_w1", 4'hB, 0, 0);
        do_lookup(4'hB); check_lookup("lk_B_cleared", 0, 0);

        do_write(3, 4'hA);
        do_lookup(4'hA); check_lookup("lk_dup_A", 1, 0);

        // Same-edge write and lookup: lookup sees the old way2 tag C.
        write_en = 1; lookup_en = 1; way_index_in = 2; tag_in = 4'h5; tick();
        check_lookup("lk_5_same_cycle", 0, 0);
        do_lookup(4'h5); check_lookup("lk_5_next_cycle", 1, 2);

        // Same-edge read of the way being written returns the old entry.
        write_en = 1; read_en = 1; way_index_in = 0; tag_in = 4'h9; tick();
        check_read("rd_no_bypass", 4'hA, 1, 0);
        do_read(0); check_read("rd_after_write", 4'h9, 1, 0);

        // Update priority.
        write_en = 1; valid_clear = 1; way_index_in = 1; tag_in = 4'h7; tick();
        do_read(1); check_read("prio_write_over_vclr", 4'h7, 1, 0);
        dirty_set = 1; dirty_clear = 1; way_index_in = 1; tick();
        do_read(1); check_read("prio_dset_over_dclr", 4'h7, 1, 1);
        valid_clear = 1; dirty_set = 1; way_index_in = 1; tick();
        do_read(1); check_read("prio_vclr_over_dset", 4'h7, 0, 0);

        // Get non-zero outputs, then reset asynchronously mid-cycle.
        do_write(1, 4'h7);
        do_read(1);
        do_lookup(4'h9);
        check_lookup("pre_reset_lk", 1, 0);
        #3;
        rst_n = 1;
        #1;
        check_read("async_reset_rd", 4'h0, 0, 0);
        check_lookup("async_reset_lk", 0, 0);

        // Strobes during reset are ignored.
        write_en = 1; lookup_en = 1; way_index_in = 2; tag_in = 4'h3; tick();
        check_lookup("lk_during_reset", 0, 0);
        rst_n = 0;

        do_lookup(4'h9); check_lookup("post_reset_lk_9", 0, 0);
        do_lookup(4'h7); check_lookup("post_reset_lk_7", 0, 0);
        do_lookup(4'h5); check_lookup("post_reset_lk_5", 0, 0);
        do_lookup(4'h3); check_lookup("post_reset_lk_3", 0, 0);
        do_lookup(4'h0); check_lookup("post_reset_lk_0", 0, 0);
        do_read(2); check_read("post_reset_rd_w2", 4'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
